// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - diagonal-skew row feed sequencer for an N x N systolic multiplier
module systolic_feed_ctrl #(
    parameter int N = 4,
    parameter int K = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [$clog2(K+1)-1:0]   k_len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [N-1:0]             shift_o,
    output logic [N-1:0]             zero_o,
    output logic                     acc_clr_o,
    output logic                     acc_en_o
);
    localparam int CW  = $clog2(K + 2 * N);
    localparam int CW1 = CW + 1;
    localparam int LW  = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_t;
    logic [CW-1:0]   w_t_nxt;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   w_len_nxt;
    logic [LW-1:0]   w_len_clamp;
    logic [CW-1:0]   w_t_last;
    logic [N-1:0]    w_shift;
    logic            r_rst_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_len      <= '0;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_len      <= w_len_nxt;
            r_rst_hold <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_len_nxt   = r_len;
        w_len_clamp = (k_len_i > LW'(K)) ? LW'(K) : k_len_i;
        // Last step index T-1 = L + 2N - 2
        w_t_last    = CW'(r_len) + CW'(2 * N - 2);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_len_clamp != '0) begin
                        w_len_nxt   = w_len_clamp;
                        w_t_nxt     = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (r_t == w_t_last) begin
                    w_t_nxt     = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_t_nxt = r_t + CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Row r owns the window r <= t < r + L
        w_shift = '0;
        for (int r = 0; r < N; r++) begin
            w_shift[r] = (r_state == S_RUN) && (r_t >= CW'(r)) &&
                         (CW1'(r_t) < (CW1'(r) + CW1'(r_len)));
        end

        shift_o   = w_shift;
        // The cycle right after a reset shows every output low, lane zeroing included
        zero_o    = r_rst_hold ? '0 : ~w_shift;
        busy_o    = (r_state == S_RUN) || (r_state == S_DONE);
        done_o    = (r_state == S_DONE);
        acc_en_o  = (r_state == S_RUN);
        acc_clr_o = (r_state == S_RUN) && (r_t == '0);
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - scoreboard bench for systolic_feed_ctrl
module tb_systolic_feed_ctrl;
    localparam int N = 4;
    localparam int K = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [3:0]   k_len_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] shift_o;
    logic [N-1:0] zero_o;
    logic         acc_clr_o;
    logic         acc_en_o;

    systolic_feed_ctrl #(.N(N), .K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .k_len_i   (k_len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .shift_o   (shift_o),
        .zero_o    (zero_o),
        .acc_clr_o (acc_clr_o),
        .acc_en_o  (acc_en_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc++;
        rst_seen <= reset;
    end

    typedef struct {
        int base;
        int len;
        int done_off;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    int sh_cnt[N];
    int first_sh[N];
    int clr_cnt, en_cnt, busy_cnt;

    task automatic clear_acc();
        for (int r = 0; r < N; r++) begin
            sh_cnt[r]   = 0;
            first_sh[r] = -1;
        end
        clr_cnt  = 0;
        en_cnt   = 0;
        busy_cnt = 0;
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        logic [N-1:0] inv;
        exp_t         e;
        if (rst_seen) begin
            chk("reset_outputs_zero",
                int'({busy_o, done_o, acc_clr_o, acc_en_o, shift_o, zero_o}), 0);
            clear_acc();
        end else begin
            inv = ~shift_o;
            chk("zero_is_not_shift", int'(zero_o), int'(inv));
            for (int r = 0; r < N; r++) begin
                if (shift_o[r]) begin
                    sh_cnt[r]++;
                    if (first_sh[r] < 0) first_sh[r] = cyc;
                end
            end
            if (acc_clr_o) clr_cnt++;
            if (acc_en_o)  en_cnt++;
            if (busy_o)    busy_cnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.base + e.done_off);
                    for (int r = 0; r < N; r++) begin
                        chk($sformatf("row%0d_pulses", r), sh_cnt[r], e.len);
                        if (e.len > 0)
                            chk($sformatf("row%0d_first_shift", r), first_sh[r], e.base + 1 + r);
                    end
                    chk("acc_clr_count", clr_cnt, (e.len > 0) ? 1 : 0);
                    chk("acc_en_count", en_cnt, (e.len > 0) ? e.done_off - 1 : 0);
                    chk("busy_count", busy_cnt, e.done_off);
                end
                clear_acc();
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_job(input int k, input int len, input int done_off);
        start_i = 1'b1;
        k_len_i = 4'(k);
        exp_q.push_back('{base: cyc, len: len, done_off: done_off});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_drain();
    endtask

    // k_len_i, clamped L, done offset (L=0 -> 1, else L + 2N)
    int vec_k[9]   = '{3, 15, 0, 1, 5, 8, 2, 7, 9};
    int vec_l[9]   = '{3,  8, 0, 1, 5, 8, 2, 7, 8};
    int vec_off[9] = '{11, 16, 1, 9, 13, 16, 10, 15, 16};

    initial begin
        int c;
        reset   = 1'b1;
        start_i = 1'b0;
        k_len_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_job(vec_k[i], vec_l[i], vec_off[i]);

        // start held high: acceptances spaced T+2 = 11 cycles for L=2
        c = cyc;
        start_i = 1'b1;
        k_len_i = 4'd2;
        exp_q.push_back('{base: c,      len: 2, done_off: 10});
        exp_q.push_back('{base: c + 11, len: 2, done_off: 10});
        exp_q.push_back('{base: c + 22, len: 2, done_off: 10});
        wait_drain();
        start_i = 1'b0;
        @(posedge clk);
        #1;

        // abandon an L=8 job at t=4; no done may follow
        start_i = 1'b1;
        k_len_i = 4'd8;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run_job(8, 8, 16);
        run_job(4, 4, 12);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
